// File: rtl/ven_pkg.sv
// ven_pkg: state, product, coin and price constants shared by the vending datapath.
package ven_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
    localparam logic [1:0] PROD_NONE = 2'b00;
    localparam logic [1:0] PROD_NEWS = 2'b01;
    localparam logic [1:0] PROD_CADBURY = 2'b10;
    localparam logic [1:0] PROD_JUICE = 2'b11;
    localparam logic [4:0] COIN_1 = 5'd1;
    localparam logic [4:0] COIN_5 = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam int PRICE_NEWS_DEF = 5;
    localparam int PRICE_CADBURY_DEF = 10;
    localparam int PRICE_JUICE_DEF = 15;
    function automatic logic [4:0] greedy_coin(input logic [4:0] amt);
        return amt >= COIN_10 ? COIN_10 : amt >= COIN_5 ? COIN_5 : COIN_1;
    endfunction
endpackage

// File: rtl/ven_sale_ctrl_if.sv
// ven_sale_ctrl_if: coin, keypad, dispenser and change hopper signals of the sale controller.
interface ven_sale_ctrl_if;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic       select_valid;
    logic [1:0] select_product;
    logic       cancel;
    logic       disp_req;
    logic [1:0] disp_product;
    logic       disp_ack;
    logic       change_valid;
    logic [4:0] change_coin;
    logic       change_ready;
    logic [4:0] credit;
    logic       coin_reject;
    logic       short_credit;
    logic       disp_fault;
    logic       busy;
    modport master (
        input  coin_valid, coin_value, select_valid, select_product, cancel, disp_ack, change_ready,
        output disp_req, disp_product, change_valid, change_coin, credit, coin_reject, short_credit,
               disp_fault, busy
    );
    modport slave (
        output coin_valid, coin_value, select_valid, select_product, cancel, disp_ack, change_ready,
        input  disp_req, disp_product, change_valid, change_coin, credit, coin_reject, short_credit,
               disp_fault, busy
    );
endinterface

// File: rtl/ven_change_dispenser.sv
// ven_change_dispenser: pays a loaded amount out greedily, one coin per valid/ready handshake.
module ven_change_dispenser import ven_pkg::*; (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] amount,
    input  logic       change_ready,
    output logic       change_valid,
    output logic [4:0] change_coin,
    output logic       done
);
    logic [4:0] rem;
    // done flags the final handshake, or an empty amount with nothing offered
    assign done = change_valid ? change_ready && rem == change_coin : rem == '0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            change_valid <= 1'b0;
            change_coin <= '0;
        end else if (load) begin
            rem <= amount;
            change_valid <= 1'b0;
        end else if (change_valid && change_ready) begin
            rem <= rem - change_coin;
            change_valid <= 1'b0;
        end else if (rem != '0) begin
            change_valid <= 1'b1;
            change_coin <= greedy_coin(rem);
        end
    end
endmodule

// File: rtl/ven_sale_ctrl.sv
// ven_sale_ctrl: credit accumulation, selection arbitration, dispense handshake and change payout.
module ven_sale_ctrl import ven_pkg::*; #(
    parameter int PRICE_NEWS = PRICE_NEWS_DEF,
    parameter int PRICE_CADBURY = PRICE_CADBURY_DEF,
    parameter int PRICE_JUICE = PRICE_JUICE_DEF,
    parameter int CREDIT_MAX = 31,
    parameter int IDLE_TIMEOUT = 200,
    parameter int DISP_TIMEOUT = 50
) (
    input logic clock,
    input logic reset,
    ven_sale_ctrl_if.master bus
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int DW = $clog2(DISP_TIMEOUT + 1);
    function automatic logic [4:0] price_of(input logic [1:0] p);
        return p == PROD_NEWS ? 5'(PRICE_NEWS) : p == PROD_CADBURY ? 5'(PRICE_CADBURY) : 5'(PRICE_JUICE);
    endfunction
    state_t state;
    logic [IW-1:0] idle_cnt;
    logic [DW-1:0] disp_cnt;
    logic [5:0] sum;
    logic coin_acc, sel_ok, idle_to, disp_to, chg_load, done;
    logic [4:0] sel_price, chg_amt;
    assign sum = {1'b0, bus.credit} + {1'b0, bus.coin_value};
    assign coin_acc = bus.coin_valid && sum <= 6'(CREDIT_MAX) &&
                      (bus.coin_value == COIN_1 || bus.coin_value == COIN_5 || bus.coin_value == COIN_10);
    assign sel_ok = bus.select_valid && bus.select_product != PROD_NONE;
    assign sel_price = price_of(bus.select_product);
    assign idle_to = idle_cnt == IW'(IDLE_TIMEOUT - 1);
    assign disp_to = disp_cnt == DW'(DISP_TIMEOUT - 1);
    // cancel, idle timeout and dispense timeout all hand the credit to the payout engine
    assign chg_load = (state == CREDIT && (bus.cancel || (!sel_ok && !coin_acc && idle_to))) ||
                      (state == DISPENSE && !bus.disp_ack && disp_to);
    assign chg_amt = state == DISPENSE ? bus.credit + price_of(bus.disp_product) : bus.credit;
    ven_change_dispenser u_chg (
        .clock(clock),
        .reset(reset),
        .load(chg_load),
        .amount(chg_amt),
        .change_ready(bus.change_ready),
        .change_valid(bus.change_valid),
        .change_coin(bus.change_coin),
        .done(done)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bus.credit <= '0;
            bus.disp_req <= 1'b0;
            bus.disp_product <= PROD_NONE;
            bus.coin_reject <= 1'b0;
            bus.short_credit <= 1'b0;
            bus.disp_fault <= 1'b0;
            bus.busy <= 1'b0;
            idle_cnt <= '0;
            disp_cnt <= '0;
        end else begin
            bus.coin_reject <= 1'b0;
            bus.short_credit <= 1'b0;
            bus.disp_fault <= 1'b0;
            if (chg_load) begin
                state <= CHANGE;
                bus.busy <= 1'b1;
                bus.credit <= chg_amt;
                bus.disp_req <= 1'b0;
                bus.disp_fault <= state == DISPENSE;
                bus.coin_reject <= bus.coin_valid;
                idle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.coin_reject <= bus.coin_valid && !coin_acc;
                        if (coin_acc) begin
                            bus.credit <= sum[4:0];
                            state <= CREDIT;
                            idle_cnt <= '0;
                        end
                    end
                    CREDIT: begin
                        if (sel_ok) begin
                            bus.coin_reject <= bus.coin_valid;
                            idle_cnt <= '0;
                            if (bus.credit >= sel_price) begin
                                bus.credit <= bus.credit - sel_price;
                                bus.disp_req <= 1'b1;
                                bus.disp_product <= bus.select_product;
                                bus.busy <= 1'b1;
                                disp_cnt <= '0;
                                state <= DISPENSE;
                            end else bus.short_credit <= 1'b1;
                        end else if (coin_acc) begin
                            bus.credit <= sum[4:0];
                            idle_cnt <= '0;
                        end else begin
                            bus.coin_reject <= bus.coin_valid;
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    DISPENSE: begin
                        bus.coin_reject <= bus.coin_valid;
                        if (bus.disp_ack) begin
                            bus.disp_req <= 1'b0;
                            bus.busy <= 1'b0;
                            idle_cnt <= '0;
                            state <= bus.credit != '0 ? CREDIT : IDLE;
                        end else disp_cnt <= disp_cnt + 1'b1;
                    end
                    default: begin
                        bus.coin_reject <= bus.coin_valid;
                        if (bus.change_valid && bus.change_ready) bus.credit <= bus.credit - bus.change_coin;
                        if (done) begin
                            state <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ven_sale_ctrl.sv
// tb_ven_sale_ctrl: directed vectors with hand-computed expectations for the sale controller.
module tb_ven_sale_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    ven_sale_ctrl_if bus();
    ven_sale_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clock);
    endtask
    task automatic coin(input logic [4:0] v);
        bus.coin_valid = 1'b1;
        bus.coin_value = v;
        tick();
        bus.coin_valid = 1'b0;
    endtask
    task automatic sel(input logic [1:0] p);
        bus.select_valid = 1'b1;
        bus.select_product = p;
        tick();
        bus.select_valid = 1'b0;
    endtask
    task automatic do_cancel();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
    endtask
    task automatic ack();
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
    endtask
    task automatic take_coin(input string tag, input logic [4:0] exp);
        int n = 0;
        while (!bus.change_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.change_valid), 1);
        check({tag, "_coin"}, 32'(bus.change_coin), 32'(exp));
        tick();
    endtask
    initial begin
        int n;
        bus.coin_valid = 1'b0;
        bus.coin_value = '0;
        bus.select_valid = 1'b0;
        bus.select_product = '0;
        bus.cancel = 1'b0;
        bus.disp_ack = 1'b0;
        bus.change_ready = 1'b1;
        tick();
        tick();
        check("rst_credit", 32'(bus.credit), 0);
        check("rst_disp_req", 32'(bus.disp_req), 0);
        check("rst_change_valid", 32'(bus.change_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset = 1'b1;
        tick();
        // buy juice with 10+5
        coin(10);
        check("t1_credit10", 32'(bus.credit), 10);
        coin(5);
        check("t1_credit15", 32'(bus.credit), 15);
        sel(2'b11);
        check("t1_req", 32'(bus.disp_req), 1);
        check("t1_prod", 32'(bus.disp_product), 3);
        check("t1_credit0", 32'(bus.credit), 0);
        check("t1_busy", 32'(bus.busy), 1);
        tick();
        check("t1_req_hold", 32'(bus.disp_req), 1);
        ack();
        check("t1_req_drop", 32'(bus.disp_req), 0);
        check("t1_idle", 32'(bus.busy), 0);
        // short credit, then cancel
        coin(10);
        sel(2'b11);
        check("t2_short", 32'(bus.short_credit), 1);
        check("t2_credit", 32'(bus.credit), 10);
        check("t2_no_req", 32'(bus.disp_req), 0);
        tick();
        check("t2_short_pulse", 32'(bus.short_credit), 0);
        do_cancel();
        check("t2_busy", 32'(bus.busy), 1);
        take_coin("t2_c0", 10);
        check("t2_credit0", 32'(bus.credit), 0);
        check("t2_idle", 32'(bus.busy), 0);
        check("t2_valid_off", 32'(bus.change_valid), 0);
        // overflow reject, purchase, stalled payout
        coin(10);
        coin(10);
        coin(10);
        check("t3_credit30", 32'(bus.credit), 30);
        coin(5);
        check("t3_reject", 32'(bus.coin_reject), 1);
        check("t3_credit_hold", 32'(bus.credit), 30);
        sel(2'b01);
        check("t3_credit25", 32'(bus.credit), 25);
        check("t3_prod", 32'(bus.disp_product), 1);
        ack();
        check("t3_after_ack", 32'(bus.credit), 25);
        bus.change_ready = 1'b0;
        do_cancel();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_valid", 32'(bus.change_valid), 1);
            check("t3_stall_coin", 32'(bus.change_coin), 10);
            check("t3_stall_credit", 32'(bus.credit), 25);
            if (i < 2) tick();
        end
        bus.change_ready = 1'b1;
        take_coin("t3_c0", 10);
        check("t3_credit15", 32'(bus.credit), 15);
        take_coin("t3_c1", 10);
        take_coin("t3_c2", 5);
        check("t3_credit0", 32'(bus.credit), 0);
        check("t3_idle", 32'(bus.busy), 0);
        // dispense timeout restores price
        coin(10);
        sel(2'b10);
        check("t4_credit0", 32'(bus.credit), 0);
        n = 0;
        while (!bus.disp_fault && n < 60) begin
            tick();
            n++;
        end
        check("t4_fault", 32'(bus.disp_fault), 1);
        check("t4_fault_cycles", 32'(n), 50);
        check("t4_req_drop", 32'(bus.disp_req), 0);
        check("t4_restored", 32'(bus.credit), 10);
        take_coin("t4_c0", 10);
        check("t4_credit0_end", 32'(bus.credit), 0);
        // cancel beats select and coin
        coin(10);
        coin(5);
        bus.cancel = 1'b1;
        bus.select_valid = 1'b1;
        bus.select_product = 2'b01;
        bus.coin_valid = 1'b1;
        bus.coin_value = 5;
        tick();
        bus.cancel = 1'b0;
        bus.select_valid = 1'b0;
        bus.coin_valid = 1'b0;
        check("t5_reject", 32'(bus.coin_reject), 1);
        check("t5_busy", 32'(bus.busy), 1);
        check("t5_credit", 32'(bus.credit), 15);
        check("t5_no_req", 32'(bus.disp_req), 0);
        take_coin("t5_c0", 10);
        take_coin("t5_c1", 5);
        check("t5_idle", 32'(bus.busy), 0);
        coin(7);
        check("t5_illegal", 32'(bus.coin_reject), 1);
        check("t5_illegal_credit", 32'(bus.credit), 0);
        // idle timeout refund
        coin(5);
        for (int i = 0; i < 190; i++) tick();
        check("t6_not_yet", 32'(bus.busy), 0);
        check("t6_credit", 32'(bus.credit), 5);
        take_coin("t6_c0", 5);
        check("t6_credit0", 32'(bus.credit), 0);
        // asynchronous reset during dispense
        coin(10);
        sel(2'b01);
        check("t7_req", 32'(bus.disp_req), 1);
        #2 reset = 1'b0;
        #1;
        check("t7_req_clr", 32'(bus.disp_req), 0);
        check("t7_credit_clr", 32'(bus.credit), 0);
        check("t7_busy_clr", 32'(bus.busy), 0);
        tick();
        reset = 1'b1;
        tick();
        check("t7_after", 32'(bus.credit), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ven_sale_ctrl.md
Name: ven_sale_ctrl

Overview:
Transaction sequencer for the vending datapath. Accumulates inserted coins into a credit register and arbitrates cancel, product selection and coin events. Drives the shared dispense mechanism through a req/ack handshake, then pays out change one coin at a time through a valid/ready handshake. Sits between the coin acceptor and keypad on one side and the dispenser and change hopper on the other.

Parameters:
PRICE_NEWS, 5, price of newspaper (select code 2'b01)
PRICE_CADBURY, 10, price of cadbury bar (select code 2'b10)
PRICE_JUICE, 15, price of tropicana juice (select code 2'b11)
CREDIT_MAX, 31, maximum credit; must fit 5 bits
IDLE_TIMEOUT, 200, CREDIT cycles with no event before auto-refund
DISP_TIMEOUT, 50, DISPENSE cycles without disp_ack before fault

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
coin_valid  in  1  one-cycle strobe, coin present
coin_value  in  5  coin value; only 1, 5 and 10 are legal
select_valid  in  1  one-cycle strobe, product selected
select_product  in  2  01 newspaper, 10 cadbury, 11 juice; 00 is ignored
cancel  in  1  one-cycle strobe, refund request
disp_req  out  1  dispense request, held until ack
disp_product  out  2  product code, stable while disp_req=1
disp_ack  in  1  dispenser done, one cycle
change_valid  out  1  change coin offered
change_coin  out  5  value of the coin offered (10, 5 or 1)
change_ready  in  1  hopper accepts the coin
credit  out  5  current credit
coin_reject  out  1  one-cycle pulse, coin returned unaccepted
short_credit  out  1  one-cycle pulse, selection refused for insufficient credit
disp_fault  out  1  one-cycle pulse, dispense timeout
busy  out  1  high in DISPENSE and CHANGE

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; credit=0; timers=0; all outputs 0.
- All outputs are registered.
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- Coin acceptance (IDLE/CREDIT only):
  - A coin is accepted if coin_value ∈ {1,5,10} and the 6-bit sum credit+coin_value <= CREDIT_MAX. Credit is updated the next cycle.
  - Otherwise coin_reject pulses the next cycle.
  - An accepted coin in IDLE moves the state to CREDIT.
- Any coin_valid in DISPENSE/CHANGE: coin_reject pulses and credit is unchanged.
- Event priority in CREDIT, same cycle: cancel > select > coin.
  - A coin dropped because a higher-priority event won pulses coin_reject.
- cancel in CREDIT -> CHANGE. cancel is ignored in IDLE, DISPENSE and CHANGE.
- select_valid in CREDIT with a legal code:
  - credit >= price: credit -= price; disp_req=1 and disp_product=code from the next cycle; state -> DISPENSE.
  - credit < price: short_credit pulses; state stays CREDIT; credit unchanged.
  - Code 00, or select_valid in IDLE: ignored.
- DISPENSE:
  - disp_req and disp_product are held until disp_ack.
  - On disp_ack: disp_req=0 the next cycle. State -> CREDIT if credit>0, else IDLE. Multiple purchases per session are allowed.
  - If DISP_TIMEOUT cycles elapse without ack: disp_req drops, the price is restored to credit, disp_fault pulses, state -> CHANGE.
- CREDIT idle timer:
  - Counts cycles with no accepted coin, select or cancel.
  - Resets on any of those events.
  - Reaching IDLE_TIMEOUT -> CHANGE.
- CHANGE payout:
  - Greedy selection: offer 10 if credit>=10, else 5 if >=5, else 1.
  - change_valid/change_coin hold until change_ready.
  - A handshake occurs when change_valid & change_ready. On handshake, credit -= change_coin and the next coin is offered the following cycle, giving at most 1 coin per 2 cycles.
  - When credit reaches 0: change_valid=0; state -> IDLE.
  - change_ready without change_valid is ignored.
- Entering CHANGE with credit=0 goes straight to IDLE with no coin offered.
- credit never exceeds CREDIT_MAX and never underflows. Subtraction happens only after a >= check.
- Reset mid-operation: everything clears immediately, including a pending disp_req or change_valid. Credit is lost, as an intended power-fail behaviour.

Decomposition:
- Shared package ven_pkg holds:
  - state enum;
  - product codes PROD_NONE/NEWS/CADBURY/JUICE;
  - coin constants COIN_1/5/10;
  - default prices.
  The existing vending machine imports the same product codes.
- One sub-module: ven_change_dispenser. It performs greedy coin selection and the valid/ready payout from a loaded amount, and returns done.

Test Plan:
- Insert 10, then 5 (credit=15); select 11 -> disp_req=1, disp_product=11, credit=0. disp_ack -> IDLE, busy=0.
- Insert 10; select 11 -> short_credit pulse, credit stays 10. cancel -> change_coin=10 once, credit=0, IDLE.
- Credit 30; insert 5 -> coin_reject, credit 30. Select 01 -> credit 25. Ack, then cancel -> payout 10, 10, 5, with change_ready stalled 3 cycles on the first coin; change_coin holds while stalled.
- Credit 10; select 10 with no ack for DISP_TIMEOUT cycles -> disp_fault pulse, credit restored to 10, payout 10.
- Same cycle: cancel+select+coin in CREDIT (credit 15) -> CHANGE, coin_reject pulse. Separately, insert 7 -> coin_reject.
- Insert 5, wait IDLE_TIMEOUT -> payout 5. Assert reset during DISPENSE -> disp_req=0, credit=0 immediately.
